// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampling UART receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        EVEN = 2'd1,
        ODD  = 2'd2
    } parity_mode_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    // System clocks per oversample tick, never below one.
    function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
        int d;
        d = clk_freq / (baud * oversample);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO with show-ahead head word and a dropped-push indication.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  logic                           pop,
    input  logic [WIDTH-1:0]               data_in,
    output logic [WIDTH-1:0]               data_out,
    output logic                           empty,
    output logic                           full,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           push_dropped
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign data_out = empty ? '0 : mem[rd_ptr];

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_pop       = pop && !empty;
    assign do_push      = push && (!full || do_pop);
    assign push_dropped = push && !do_push;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with parity/frame/overrun detection feeding a receive FIFO.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_LENGTH = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int CLK_FREQ    = 25000000,
    parameter int BAUD_RATE   = 115200,
    parameter int OVERSAMPLE  = 16,
    parameter int PARITY_MODE = 0
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              serial_rx,
    input  logic                              pop,
    input  logic                              clear_errors,
    output logic [DATA_LENGTH-1:0]            rx_data,
    output logic                              empty,
    output logic                              full,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   count,
    output logic                              parity_error,
    output logic                              frame_error,
    output logic                              overrun
);

    localparam int DIV   = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OS_W  = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_LENGTH + 1);
    localparam parity_mode_e PMODE = parity_mode_e'(PARITY_MODE);

    logic [1:0]             sync_q;
    logic                   rx_s;
    rx_state_e              state;
    rx_state_e              state_next;
    logic [DIV_W-1:0]       tick_cnt;
    logic                   tick;
    logic [OS_W-1:0]        os_cnt;
    logic [OS_W-1:0]        sample_at;
    logic                   sample;
    logic [BIT_W-1:0]       bit_cnt;
    logic [DATA_LENGTH-1:0] shift;
    logic                   par_bad;
    logic                   start_entry;
    logic                   stop_done;
    logic                   word_ok;
    logic                   frame_set;
    logic                   parity_set;
    logic                   push_r;
    logic                   push_dropped;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], serial_rx};
        end
    end

    assign rx_s = sync_q[1];
    assign tick = (tick_cnt == DIV_W'(DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // START samples at mid-bit; every later phase samples one full bit apart.
    always_comb begin
        state_next  = state;
        start_entry = 1'b0;
        sample_at   = (state == START) ? OS_W'(OVERSAMPLE / 2 - 1) : OS_W'(OVERSAMPLE - 1);
        sample      = tick && (os_cnt == sample_at);
        stop_done   = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_next  = START;
                    start_entry = 1'b1;
                end
            end
            START: begin
                if (sample) begin
                    state_next = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (sample && (bit_cnt == BIT_W'(DATA_LENGTH - 1))) begin
                    state_next = (PMODE != NONE) ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (sample) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (sample) begin
                    state_next = IDLE;
                    stop_done  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        frame_set  = stop_done && !rx_s;
        parity_set = stop_done && rx_s && par_bad;
        word_ok    = stop_done && rx_s && !par_bad;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
            os_cnt   <= '0;
            bit_cnt  <= '0;
            par_bad  <= 1'b0;
            push_r   <= 1'b0;
        end else begin
            tick_cnt <= (start_entry || tick) ? '0 : tick_cnt + 1'b1;
            if (start_entry || sample) begin
                os_cnt <= '0;
            end else if (tick && (state != IDLE)) begin
                os_cnt <= os_cnt + 1'b1;
            end
            if (start_entry) begin
                bit_cnt <= '0;
            end else if ((state == DATA) && sample) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (start_entry) begin
                par_bad <= 1'b0;
            end else if ((state == PARITY) && sample) begin
                par_bad <= ((^shift) ^ rx_s) != (PMODE == ODD);
            end
            push_r <= word_ok;
        end
    end

    // LSB arrives first, so each new bit enters at the top.
    always_ff @(posedge clk) begin
        if ((state == DATA) && sample) begin
            shift <= {rx_s, shift[DATA_LENGTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            parity_error <= 1'b0;
            frame_error  <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            parity_error <= parity_set   || (parity_error && !clear_errors);
            frame_error  <= frame_set    || (frame_error  && !clear_errors);
            overrun      <= push_dropped || (overrun      && !clear_errors);
        end
    end

    sync_fifo #(
        .WIDTH (DATA_LENGTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push         (push_r),
        .pop          (pop),
        .data_in      (shift),
        .data_out     (rx_data),
        .empty        (empty),
        .full         (full),
        .count        (count),
        .push_dropped (push_dropped)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: a default no-parity instance and a fast even-parity instance.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       line0, pop0, clr0;
    logic       line1, pop1, clr1;
    logic [7:0] data0, data1;
    logic       empty0, full0, perr0, ferr0, ovr0;
    logic       empty1, full1, perr1, ferr1, ovr1;
    logic [4:0] cnt0, cnt1;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    uart_rx_fifo dut0 (
        .clk(clk), .reset(rst_n), .serial_rx(line0), .pop(pop0), .clear_errors(clr0),
        .rx_data(data0), .empty(empty0), .full(full0), .count(cnt0),
        .parity_error(perr0), .frame_error(ferr0), .overrun(ovr0)
    );

    // 16 clocks per bit: DIV = 2, OVERSAMPLE = 8.
    uart_rx_fifo #(
        .BAUD_RATE(1562500), .OVERSAMPLE(8), .PARITY_MODE(1)
    ) dut1 (
        .clk(clk), .reset(rst_n), .serial_rx(line1), .pop(pop1), .clear_errors(clr1),
        .rx_data(data1), .empty(empty1), .full(full1), .count(cnt1),
        .parity_error(perr1), .frame_error(ferr1), .overrun(ovr1)
    );

    typedef struct {
        logic [7:0] d;
        logic       pbit;
        logic       stopb;
        logic       clr;
        int         cnt;
        int         head;
        int         perr;
        int         ferr;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic set_line(input int which, input logic v);
        if (which == 0) line0 = v;
        else line1 = v;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input int which, input logic [7:0] d, input logic has_par,
                              input logic pbit, input logic stopb);
        logic [10:0] f;
        int n;
        int bclk;
        bclk = (which == 0) ? 208 : 16;
        f = '0;
        f[8:1] = d;
        if (has_par) begin f[9] = pbit; f[10] = stopb; n = 11; end
        else begin f[9] = stopb; n = 10; end
        for (int k = 0; k < n; k++) begin
            set_line(which, f[k]);
            repeat (bclk) @(negedge clk);
        end
        set_line(which, 1'b1);
    endtask

    task automatic send_p(input logic [7:0] d, input logic good, input logic stopb);
        send_frame(1, d, 1'b1, good ? ^d : ~^d, stopb);
    endtask

    task automatic pulse(input int which, input int is_pop);
        if (which == 0) begin if (is_pop != 0) pop0 = 1'b1; else clr0 = 1'b1; end
        else begin if (is_pop != 0) pop1 = 1'b1; else clr1 = 1'b1; end
        @(negedge clk);
        pop0 = 1'b0; clr0 = 1'b0; pop1 = 1'b0; clr1 = 1'b0;
    endtask

    task automatic check_dut(input int which, input string tag, input int c, input int h,
                             input int pe, input int fe, input int ov);
        int ac, ah, ae, af, ape, afe, aov;
        if (which == 0) begin
            ac = int'(cnt0); ah = int'(data0); ae = int'(empty0); af = int'(full0);
            ape = int'(perr0); afe = int'(ferr0); aov = int'(ovr0);
        end else begin
            ac = int'(cnt1); ah = int'(data1); ae = int'(empty1); af = int'(full1);
            ape = int'(perr1); afe = int'(ferr1); aov = int'(ovr1);
        end
        chk({tag, ".count"}, ac, c);
        chk({tag, ".rx_data"}, ah, h);
        chk({tag, ".empty"}, ae, (c == 0) ? 1 : 0);
        chk({tag, ".full"}, af, (c == 16) ? 1 : 0);
        chk({tag, ".parity_error"}, ape, pe);
        chk({tag, ".frame_error"}, afe, fe);
        chk({tag, ".overrun"}, aov, ov);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        logic [7:0] mq[$];
        int mp, mf, mo;
        logic [7:0] d;
        int k;
        logic good, stopb;

        tbl[0] = '{8'hA5, 1'b1, 1'b1, 1'b0, 0, 8'h00, 1, 0};
        tbl[1] = '{8'hA5, 1'b0, 1'b1, 1'b1, 1, 8'hA5, 0, 0};
        tbl[2] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1, 8'hA5, 0, 1};
        tbl[3] = '{8'h3C, 1'b0, 1'b1, 1'b1, 2, 8'hA5, 0, 0};
        tbl[4] = '{8'h07, 1'b1, 1'b1, 1'b0, 3, 8'hA5, 0, 0};
        tbl[5] = '{8'hE1, 1'b1, 1'b0, 1'b0, 3, 8'hA5, 0, 1};

        rst_n = 1'b0;
        line0 = 1'b1; pop0 = 1'b0; clr0 = 1'b0;
        line1 = 1'b1; pop1 = 1'b0; clr1 = 1'b0;
        idle(3);
        check_dut(0, "reset0", 0, 0, 0, 0, 0);
        check_dut(1, "reset1", 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        idle(5);

        // Single word, then pop.
        send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1);
        idle(4);
        check_dut(0, "t1_rx", 1, 8'h5A, 0, 0, 0);
        pulse(0, 1);
        check_dut(0, "t1_pop", 0, 0, 0, 0, 0);

        // Fill past capacity, then drain in order.
        for (int i = 0; i < 17; i++) begin
            send_frame(0, 8'(i), 1'b0, 1'b0, 1'b1);
            idle(20);
        end
        check_dut(0, "t2_full", 16, 8'h00, 0, 0, 1);
        for (int i = 0; i < 16; i++) begin
            chk("t2_head", int'(data0), i);
            pulse(0, 1);
        end
        check_dut(0, "t2_drained", 0, 0, 0, 0, 1);
        pulse(0, 1);
        check_dut(0, "t2_extra_pop", 0, 0, 0, 0, 1);
        pulse(0, 0);
        check_dut(0, "t2_clear", 0, 0, 0, 0, 0);

        // Bad stop bit, then a good frame.
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0);
        idle(420);
        check_dut(0, "t4_ferr", 0, 0, 0, 1, 0);
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
        idle(4);
        check_dut(0, "t4_ok", 1, 8'h3C, 0, 1, 0);

        // Glitch shorter than half a bit.
        line0 = 1'b0;
        idle(52);
        line0 = 1'b1;
        idle(300);
        check_dut(0, "t5_false_start", 1, 8'h3C, 0, 1, 0);

        // Reset in the middle of a frame.
        line0 = 1'b0;
        idle(208);
        for (int b = 0; b < 4; b++) begin
            line0 = (b == 0);
            idle(208);
        end
        rst_n = 1'b0;
        idle(2);
        check_dut(0, "t6_reset", 0, 0, 0, 0, 0);
        line0 = 1'b1;
        idle(3);
        rst_n = 1'b1;
        idle(20);
        send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1);
        idle(4);
        check_dut(0, "t6_after", 1, 8'h81, 0, 0, 0);

        // Even-parity instance: table of frames.
        for (int i = 0; i < 6; i++) begin
            if (tbl[i].clr) pulse(1, 0);
            send_frame(1, tbl[i].d, 1'b1, tbl[i].pbit, tbl[i].stopb);
            idle(40);
            check_dut(1, $sformatf("tbl%0d", i), tbl[i].cnt, tbl[i].head, tbl[i].perr, tbl[i].ferr, 0);
        end
        chk("tbl_pop0", int'(data1), 8'hA5); pulse(1, 1);
        chk("tbl_pop1", int'(data1), 8'h3C); pulse(1, 1);
        chk("tbl_pop2", int'(data1), 8'h07); pulse(1, 1);
        pulse(1, 0);
        check_dut(1, "tbl_end", 0, 0, 0, 0, 0);

        // Set and clear in the same cycle: the set must win.
        fork
            send_frame(1, 8'h11, 1'b1, 1'b0, 1'b0);
            begin idle(170); clr1 = 1'b1; idle(1); clr1 = 1'b0; end
        join
        idle(40);
        check_dut(1, "set_beats_clear", 0, 0, 0, 1, 0);
        pulse(1, 0);

        // Push and pop in the same cycle while full.
        for (int i = 0; i < 16; i++) begin
            send_p(8'h40 + 8'(i), 1'b1, 1'b1);
            idle(4);
        end
        check_dut(1, "fill16", 16, 8'h40, 0, 0, 0);
        fork
            send_p(8'h99, 1'b1, 1'b1);
            begin idle(171); pop1 = 1'b1; idle(1); pop1 = 1'b0; end
        join
        idle(4);
        check_dut(1, "push_pop_full", 16, 8'h41, 0, 0, 0);
        for (int i = 1; i < 17; i++) begin
            chk("pp_drain", int'(data1), (i == 16) ? 8'h99 : 8'h40 + i);
            pulse(1, 1);
        end
        check_dut(1, "pp_empty", 0, 0, 0, 0, 0);

        // Randomized frames against a queue model.
        mp = 0; mf = 0; mo = 0;
        for (int i = 0; i < 50; i++) begin
            d = 8'($urandom_range(0, 255));
            k = $urandom_range(0, 9);
            stopb = (k != 0);
            good  = (k != 1);
            if ($urandom_range(0, 4) == 0) begin
                pulse(1, 0);
                mp = 0; mf = 0; mo = 0;
            end
            send_p(d, good, stopb);
            idle(40);
            if (!stopb) mf = 1;
            else if (!good) mp = 1;
            else if (mq.size() == 16) mo = 1;
            else mq.push_back(d);
            check_dut(1, "rnd", mq.size(), (mq.size() != 0) ? int'(mq[0]) : 0, mp, mf, mo);
            if ($urandom_range(0, 9) < 4) begin
                pulse(1, 1);
                if (mq.size() != 0) void'(mq.pop_front());
                chk("rnd_pop.count", int'(cnt1), mq.size());
                chk("rnd_pop.rx_data", int'(data1), (mq.size() != 0) ? int'(mq[0]) : 0);
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised UART receiver with an integrated receive FIFO. It replaces the fixed receiver, standalone baud generator and fixed FIFO used in the UART top with a single oversampling block. Word width, parity mode, oversampling ratio and FIFO depth are configurable. It adds frame, parity and overrun detection, and the FIFO runs on the system clock instead of a baud clock.

Parameters:
DATA_LENGTH, 8, data bits per frame (5..9)
FIFO_DEPTH, 16, FIFO entries (power of 2, >=2)
CLK_FREQ, 25000000, system clock frequency in Hz
BAUD_RATE, 115200, line bit rate
OVERSAMPLE, 16, sample ticks per bit (even, >=8)
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-low reset
serial_rx  input  1  asynchronous UART line, idle high
pop  input  1  remove head word from FIFO
clear_errors  input  1  clear sticky error flags
rx_data  output  DATA_LENGTH  FIFO head word (show-ahead)
empty  output  1  FIFO empty
full  output  1  FIFO full
count  output  $clog2(FIFO_DEPTH+1)  current FIFO occupancy
parity_error  output  1  sticky parity error flag
frame_error  output  1  sticky frame (stop bit) error flag
overrun  output  1  sticky overrun flag (word dropped, FIFO full)

Behaviour:
- Reset (reset=0, asynchronous): rx_data=0, empty=1, full=0, count=0, all error flags 0, FSM=IDLE, synchroniser flops=1, pointers=0.
- serial_rx passes through a 2-flop synchroniser. All FSM decisions use the synchronised line.
- Tick generator: DIV = max(1, CLK_FREQ/(BAUD_RATE*OVERSAMPLE)), integer division. It emits a 1-cycle tick every DIV clocks and restarts from 0 on entering START. With the defaults, DIV=13 and one bit = 208 clocks.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: synchronised line = 0 -> START.
- START: wait OVERSAMPLE/2 ticks (mid-bit), then sample.
  - Sample 0 -> DATA.
  - Sample 1 -> IDLE (false start, no flags).
- DATA: sample every OVERSAMPLE ticks, shifting LSB first. After DATA_LENGTH samples -> PARITY if PARITY_MODE != 0, else -> STOP.
- PARITY: sample one bit. Mismatch = (XOR of data ^ bit) != (PARITY_MODE == 2).
- STOP: sample one bit, then -> IDLE on the same cycle.
  - Stop sample = 0: set frame_error, discard word.
  - Else if parity mismatch: set parity_error, discard word.
  - Else push the word.
- Push timing: push occurs one cycle after the stop-bit sample tick. empty deasserts and count increments on the following cycle.
- Push while full and no pop in the same cycle: word dropped, overrun set, FIFO contents unchanged.
- FIFO: circular buffer with rd/wr pointers that wrap modulo FIFO_DEPTH.
  - rx_data = mem[rd_ptr] when !empty, 0 when empty.
  - pop while empty: ignored, no flag.
- Simultaneous push and pop:
  - Both succeed and count is unchanged.
  - When full, the pop frees the slot, so the push succeeds and overrun is not set.
- Sticky flags: clear_errors=1 clears all three next cycle. If a flag is set in the same cycle as clear_errors, the set wins.
- Reset mid-frame: the frame is abandoned, the FIFO is emptied, and reception restarts at the next falling edge after reset release.

Decomposition:
- Package uart_pkg:
  - parity_mode_e enum (NONE, EVEN, ODD)
  - rx_state_e enum (IDLE, START, DATA, PARITY, STOP)
  - function calc_div(clk_freq, baud, oversample)
- Sub-module sync_fifo, parametrised by width and depth:
  - inputs: push, pop, data_in
  - outputs: data_out, empty, full, count, push_dropped
- The receive FSM and tick generator remain in uart_rx_fifo.

Test Plan:
1. Defaults; send 0x5A at 208 clk/bit, no parity -> after stop bit: empty=0, count=1, rx_data=0x5A. Then pop -> empty=1, count=0.
2. Send 17 frames 0x00..0x10 with no pop -> full=1, count=16, overrun=1. 16 pops return 0x00..0x0F in order; the 17th pop is ignored.
3. PARITY_MODE=1; send 0xA5 with parity bit 1 -> parity_error=1, empty stays 1. Pulse clear_errors -> parity_error=0. Resend 0xA5 with parity bit 0 -> word stored.
4. Send 0x3C with stop bit 0 -> frame_error=1, count stays 0. Next valid 0x3C is stored normally.
5. Pulse line low for 52 clocks (4 ticks) -> false start: FSM returns to IDLE, no push, no flags.
6. Assert reset after 4 data bits of 0x81 -> all outputs at reset values. After release, send 0x81 -> rx_data=0x81, count=1.
